// File: rtl/disp_scan_sched.sv
// disp_scan_sched
//   Scan scheduler for a 4-digit multiplexed 7-segment display.
//   Display words arrive over a valid/ready handshake into a one-deep pending
//   buffer. They are copied into the shadow (displayed) word only at a frame
//   boundary, so a digit never shows a half-updated word. The active digit is
//   time-multiplexed onto AN/SEG with brightness PWM, leading-zero blanking
//   and a lamp test.
//
// Ports
//   F50MHz     in   system clock
//   BTN0       in   synchronous active-high reset
//   dat_in     in   display word, nibble k -> digit k (digit 0 = AN[0], rightmost)
//   dat_valid  in   dat_in valid
//   dat_ready  out  pending buffer empty, a word can be accepted
//   dp_in      in   decimal point per digit, 1 = lit (live, not buffered)
//   blank_lz   in   1 = blank leading zero digits
//   bright     in   brightness code, all ones = full on
//   lamp_test  in   request all segments lit
//   AN         out  digit enables, active-low
//   SEG        out  {dp,g,f,e,d,c,b,a}, active-low
//   frame_tick out  one-cycle pulse after each frame boundary
module disp_scan_sched #(
  parameter int SCAN_DIV = 12500,
  parameter int BRIGHT_W = 3
) (
  input  logic                F50MHz,
  input  logic                BTN0,
  input  logic [15:0]         dat_in,
  input  logic                dat_valid,
  output logic                dat_ready,
  input  logic [3:0]          dp_in,
  input  logic                blank_lz,
  input  logic [BRIGHT_W-1:0] bright,
  input  logic                lamp_test,
  output logic [3:0]          AN,
  output logic [7:0]          SEG,
  output logic                frame_tick
);

  localparam int CW = $clog2(SCAN_DIV);
  // Wide enough for (2^BRIGHT_W) * SCAN_DIV and pre_cnt * 8 without overflow.
  localparam int PW = BRIGHT_W + 1 + CW + 3;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_SCAN = 2'd1,
    S_LAMP = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] pre_cnt;
  logic [1:0]    dig;
  logic [15:0]   pend;
  logic          pend_full;
  logic [15:0]   shadow;
  logic          digit_tick;
  logic          frame_end;
  logic          accept;
  logic [3:0]    nib;
  logic [3:0]    dig_sel;
  logic          blanked;
  logic          pwm_on;
  logic [PW-1:0] pwm_lhs;
  logic [PW-1:0] pwm_rhs;
  logic [3:0]    an_p0;
  logic [7:0]    seg_p0;

  // Active-high segment pattern {g,f,e,d,c,b,a} for a hex digit.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign digit_tick = (pre_cnt == CNT_MAX);
  assign frame_end  = digit_tick && (dig == 2'd3);
  // Ready is simply "pending buffer empty"; it drops the cycle after a
  // transfer and returns the cycle after the commit.
  assign dat_ready  = ~pend_full;
  assign accept     = dat_valid && dat_ready;

  // Timing, handshake and registered outputs
  always_ff @(posedge F50MHz) begin
    if (BTN0) begin
      pre_cnt    <= '0;
      dig        <= 2'd0;
      pend_full  <= 1'b0;
      shadow     <= 16'h0000;
      frame_tick <= 1'b0;
      AN         <= 4'hF;
      SEG        <= 8'hFF;
    end else begin
      pre_cnt    <= digit_tick ? '0 : pre_cnt + 1'b1;
      if (digit_tick) dig <= dig + 2'd1;
      frame_tick <= frame_end;
      AN         <= an_p0;
      SEG        <= seg_p0;
      // A transfer needs an empty buffer, so it can never collide with a
      // commit; a word accepted on a frame_end edge waits a whole frame.
      if (accept) begin
        pend_full <= 1'b1;
      end else if (frame_end && pend_full) begin
        pend_full <= 1'b0;
        shadow    <= pend;
      end
    end
  end

  // Pending data register needs no reset: pend_full qualifies it.
  always_ff @(posedge F50MHz) begin
    if (accept) pend <= dat_in;
  end

  always_ff @(posedge F50MHz) begin
    if (BTN0) state <= S_OFF;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (frame_end) begin
      case (state)
        S_OFF:   if (lamp_test) state_nxt = S_LAMP;
                 else if (pend_full) state_nxt = S_SCAN;
        S_SCAN:  if (lamp_test) state_nxt = S_LAMP;
        S_LAMP:  if (!lamp_test) state_nxt = S_SCAN;
        default: state_nxt = S_OFF;
      endcase
    end
  end

  // Stage p0: digit decode from pre_cnt/dig, registered into AN/SEG
  always_comb begin
    nib     = shadow[{dig, 2'b00} +: 4];
    dig_sel = 4'b0001 << dig;
    case (dig)
      2'd1:    blanked = blank_lz && (shadow[15:4]  == 12'h000);
      2'd2:    blanked = blank_lz && (shadow[15:8]  == 8'h00);
      2'd3:    blanked = blank_lz && (shadow[15:12] == 4'h0);
      default: blanked = 1'b0;
    endcase
    pwm_lhs = PW'(pre_cnt) << 3;
    pwm_rhs = (PW'(bright) + PW'(1)) * PW'(SCAN_DIV);
    pwm_on  = (pwm_lhs < pwm_rhs);
    an_p0   = 4'hF;
    seg_p0  = 8'hFF;
    case (state)
      S_SCAN: begin
        if (pwm_on && !blanked) begin
          an_p0  = ~dig_sel;
          seg_p0 = {~dp_in[dig], ~hex7(nib)};
        end
      end
      S_LAMP: begin
        an_p0  = ~dig_sel;
        seg_p0 = 8'h00;
      end
      default: begin
        an_p0  = 4'hF;
        seg_p0 = 8'hFF;
      end
    endcase
  end

endmodule

// File: tb/tb_disp_scan_sched.sv
// tb_disp_scan_sched
//   Directed bench for disp_scan_sched with SCAN_DIV=8 (32-clock frame).
//   Expected AN/SEG per clock are queued per digit slot and popped as the
//   display produces them.
module tb_disp_scan_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] dat_in;
  logic        dat_valid;
  logic        dat_ready;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [2:0]  bright;
  logic        lamp_test;
  logic [3:0]  AN;
  logic [7:0]  SEG;
  logic        frame_tick;

  always #5 clk = ~clk;

  disp_scan_sched #(.SCAN_DIV(8), .BRIGHT_W(3)) dut (
    .F50MHz     (clk),
    .BTN0       (rst),
    .dat_in     (dat_in),
    .dat_valid  (dat_valid),
    .dat_ready  (dat_ready),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .bright     (bright),
    .lamp_test  (lamp_test),
    .AN         (AN),
    .SEG        (SEG),
    .frame_tick (frame_tick)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] seg;
  } exp_t;

  exp_t sb[$];
  int vectors     = 0;
  int miscompares = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  // One digit slot: lit for n_on clocks, dark for the rest.
  task automatic push_slot(input logic [3:0] an, input logic [7:0] seg, input int n_on);
    for (int i = 0; i < 8; i++) begin
      if (i < n_on) sb.push_back({an, seg});
      else          sb.push_back({4'hF, 8'hFF});
    end
  endtask

  task automatic push_blank_frame();
    for (int d = 0; d < 4; d++) push_slot(4'hF, 8'hFF, 0);
  endtask

  // Checks 32 clocks against the queue; frame_tick expected only on the last.
  // lamp_test is changed to lamp_val after sample chg_at (-1 = never).
  task automatic check_frame(input string tag, input int chg_at, input logic lamp_val);
    exp_t e;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (i == chg_at) lamp_test = lamp_val;
      e = '0;
      if (sb.size() > 0) e = sb.pop_front();
      check($sformatf("%s[%0d]", tag, i), {19'd0, AN, SEG, frame_tick},
            {19'd0, e.an, e.seg, (i == 31)});
    end
  endtask

  task automatic wait_frame(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_tick && n < 40);
    check(tag, {31'd0, frame_tick}, 32'd1);
  endtask

  task automatic send(input logic [15:0] w);
    dat_in    = w;
    dat_valid = 1'b1;
    tick();
    dat_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    dat_in    = 16'h0000;
    dat_valid = 1'b0;
    dp_in     = 4'h0;
    blank_lz  = 1'b0;
    bright    = 3'd7;
    lamp_test = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_an",    {28'd0, AN},         32'hF);
    check("rst_seg",   {24'd0, SEG},        32'hFF);
    check("rst_ready", {31'd0, dat_ready},  32'd1);
    check("rst_tick",  {31'd0, frame_tick}, 32'd0);
    rst = 1'b0;

    // OFF with no data: two blank frames
    push_blank_frame();
    push_blank_frame();
    check_frame("off_a", -1, 1'b0);
    check_frame("off_b", -1, 1'b0);

    // First word, full brightness
    send(16'h12AF);
    check("t2_ready_low", {31'd0, dat_ready}, 32'd0);
    wait_frame("t2_frame");
    check("t2_ready_back", {31'd0, dat_ready}, 32'd1);
    push_slot(4'hE, 8'h8E, 8);
    push_slot(4'hD, 8'h88, 8);
    push_slot(4'hB, 8'hA4, 8);
    push_slot(4'h7, 8'hF9, 8);
    check_frame("t2_scan", -1, 1'b0);

    // Second word while pending is ignored
    send(16'h3456);
    check("t3_ready_low", {31'd0, dat_ready}, 32'd0);
    dat_in    = 16'h0042;
    dat_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_ready_hold", {31'd0, dat_ready}, 32'd0);
    end
    dat_valid = 1'b0;
    wait_frame("t3_frame");
    check("t3_ready_back", {31'd0, dat_ready}, 32'd1);
    push_slot(4'hE, 8'h82, 8);
    push_slot(4'hD, 8'h92, 8);
    push_slot(4'hB, 8'h99, 8);
    push_slot(4'h7, 8'hB0, 8);
    check_frame("t3_3456", -1, 1'b0);

    // Leading-zero blanking
    blank_lz = 1'b1;
    send(16'h0042);
    wait_frame("t3_frame_lz");
    push_slot(4'hE, 8'hA4, 8);
    push_slot(4'hD, 8'h99, 8);
    push_slot(4'hF, 8'hFF, 0);
    push_slot(4'hF, 8'hFF, 0);
    check_frame("t3_lz", -1, 1'b0);

    // Brightness PWM
    bright = 3'd1;
    push_slot(4'hE, 8'hA4, 2);
    push_slot(4'hD, 8'h99, 2);
    push_blank_frame_half();
    check_frame("t4_b1", -1, 1'b0);
    bright = 3'd0;
    push_slot(4'hE, 8'hA4, 1);
    push_slot(4'hD, 8'h99, 1);
    push_blank_frame_half();
    check_frame("t4_b0", -1, 1'b0);
    bright = 3'd7;

    // Lamp test: requested mid-frame, takes effect at the frame boundary
    push_slot(4'hE, 8'hA4, 8);
    push_slot(4'hD, 8'h99, 8);
    push_blank_frame_half();
    check_frame("t5_pre", 12, 1'b1);
    bright = 3'd0;
    push_slot(4'hE, 8'h00, 8);
    push_slot(4'hD, 8'h00, 8);
    push_slot(4'hB, 8'h00, 8);
    push_slot(4'h7, 8'h00, 8);
    check_frame("t5_lamp", 5, 1'b0);
    bright = 3'd7;
    push_slot(4'hE, 8'hA4, 8);
    push_slot(4'hD, 8'h99, 8);
    push_blank_frame_half();
    check_frame("t5_back", -1, 1'b0);

    // Reset mid-frame with a pending word
    send(16'h9999);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check("t6_rst_an",    {28'd0, AN},         32'hF);
    check("t6_rst_seg",   {24'd0, SEG},        32'hFF);
    check("t6_rst_ready", {31'd0, dat_ready},  32'd1);
    check("t6_rst_tick",  {31'd0, frame_tick}, 32'd0);
    rst = 1'b0;
    push_blank_frame();
    push_blank_frame();
    check_frame("t6_off_a", -1, 1'b0);
    check_frame("t6_off_b", -1, 1'b0);

    // Transfer on the same edge as frame_end commits one frame later
    repeat (31) tick();
    dat_in    = 16'h0707;
    dat_valid = 1'b1;
    tick();
    dat_valid = 1'b0;
    check("t6_coincide_tick", {31'd0, frame_tick}, 32'd1);
    check("t6_coincide_ready", {31'd0, dat_ready}, 32'd0);
    dp_in = 4'b1101;
    push_blank_frame();
    check_frame("t6_wait", -1, 1'b0);
    check("t6_ready_back", {31'd0, dat_ready}, 32'd1);
    push_slot(4'hE, 8'h78, 8);
    push_slot(4'hD, 8'hC0, 8);
    push_slot(4'hB, 8'h78, 8);
    push_slot(4'hF, 8'hFF, 0);
    check_frame("t6_commit", -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Digits 2 and 3 dark for a whole slot each.
  task automatic push_blank_frame_half();
    push_slot(4'hF, 8'hFF, 0);
    push_slot(4'hF, 8'hFF, 0);
  endtask

endmodule
